// File: rtl/swervolf_sevseg_pkg.sv
// Shared definitions for the seven-segment scanner: FSM states,
// Wishbone register map, scan timing and a byte-lane merge helper.
package swervolf_sevseg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  // Register word offsets, decoded from i_wb_adr[4:2]
  localparam logic [2:0] REG_DIGITS_L = 3'd0;
  localparam logic [2:0] REG_DIGITS_H = 3'd1;
  localparam logic [2:0] REG_CTRL     = 3'd2;
  localparam logic [2:0] REG_PRESCALE = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  // Scan timing in prescaler ticks per digit
  localparam int ON_TICKS    = 16;
  localparam int BLANK_TICKS = 1;

  localparam logic [3:0] ON_LAST    = 4'(ON_TICKS - 1);
  localparam logic [3:0] BLANK_LAST = 4'(BLANK_TICKS - 1);

  // Replace only the byte lanes selected by sel
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = cur;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) begin
        res[i*8 +: 8] = wdat[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = cur[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/swervolf_sevseg_prescaler.sv
// Scan tick generator: down-counts from the programmed prescale value and
// fires one tick when the count reaches zero, then reloads. A prescale of 0
// behaves like 1 (a tick every clock). The reload value is sampled at each
// reload, so a new prescale takes effect from the next reload.
module swervolf_sevseg_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic [15:0] reload,
  output logic        tick
);

  logic [15:0] cnt_r;
  logic [15:0] start_s;

  // Start value for a period of max(reload, 1) clocks
  always_comb begin
    start_s = 16'd0;
    if (reload == 16'd0) begin
      start_s = 16'd0;
    end else begin
      start_s = reload - 16'd1;
    end
  end

  // Down-counter; held at the start value while cleared, reloaded on tick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 16'd0;
    end else if (clear || (cnt_r == 16'd0)) begin
      cnt_r <= start_s;
    end else begin
      cnt_r <= cnt_r - 16'd1;
    end
  end

  assign tick = (cnt_r == 16'd0);

endmodule

// File: rtl/swervolf_sevseg_scan.sv
// Wishbone-controlled multiplexed driver for an 8-digit seven-segment
// display. Software writes shadow digit registers; the scanner copies them
// into the active set only at frame boundaries so a frame never tears.
module swervolf_sevseg_scan
  import swervolf_sevseg_pkg::*;
#(
  parameter logic [15:0] DEF_PRESCALE = 16'd6250
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_frame_irq,
  output logic [7:0]  AN,
  output logic [6:0]  Digits_Bits
);

  // Bus side
  logic        ack_r;
  logic [31:0] rdt_r;
  logic        wb_req_s;
  logic        wb_wr_s;
  logic [2:0]  reg_sel_s;
  logic [31:0] rd_data_s;
  logic        unused_s;

  // Programmable registers
  logic [31:0] shadow_l_r;
  logic [31:0] shadow_h_r;
  logic [31:0] active_l_r;
  logic [31:0] active_h_r;
  logic        scan_en_r;
  logic        irq_en_r;
  logic [3:0]  bright_r;
  logic [15:0] prescale_r;

  // Scanner state
  scan_state_e state_r;
  scan_state_e state_n_s;
  logic [2:0]  digit_r;
  logic [2:0]  digit_n_s;
  logic [3:0]  on_cnt_r;
  logic [3:0]  on_cnt_n_s;
  logic [15:0] frame_cnt_r;
  logic        frame_s;
  logic        copy_s;
  logic        clear_s;
  logic        tick_s;
  logic        irq_r;

  // Display path
  logic [63:0] active_all_s;
  logic [7:0]  digit_byte_s;
  logic        lit_s;
  logic [7:0]  an_n_s;
  logic [6:0]  seg_n_s;
  logic [7:0]  an_r;
  logic [6:0]  seg_r;

  assign wb_req_s  = i_wb_cyc & i_wb_stb & ~ack_r;
  assign wb_wr_s   = wb_req_s & i_wb_we;
  assign reg_sel_s = i_wb_adr[4:2];
  assign unused_s  = &{1'b0, i_wb_adr[1:0]};

  assign o_wb_ack    = ack_r;
  assign o_wb_rdt    = rdt_r;
  assign o_frame_irq = irq_r;
  assign AN          = an_r;
  assign Digits_Bits = seg_r;

  swervolf_sevseg_prescaler u_prescaler (
    .clk    (i_clk),
    .rst    (i_rst),
    .clear  (clear_s),
    .reload (prescale_r),
    .tick   (tick_s)
  );

  // Read data multiplexer; unmapped offsets read as zero
  always_comb begin
    rd_data_s = 32'd0;
    case (reg_sel_s)
      REG_DIGITS_L: rd_data_s = shadow_l_r;
      REG_DIGITS_H: rd_data_s = shadow_h_r;
      REG_CTRL:     rd_data_s = {20'd0, bright_r, 6'd0, irq_en_r, scan_en_r};
      REG_PRESCALE: rd_data_s = {16'd0, prescale_r};
      REG_STATUS:   rd_data_s = {frame_cnt_r, 10'd0, state_r, 1'b0, digit_r};
      default:      rd_data_s = 32'd0;
    endcase
  end

  // Wishbone handshake: one wait state per access, read data captured with ack
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_r <= 1'b0;
      rdt_r <= 32'd0;
    end else begin
      ack_r <= i_wb_cyc & i_wb_stb & ~ack_r;
      if (wb_req_s) begin
        rdt_r <= rd_data_s;
      end
    end
  end

  // Register writes with per-byte-lane enables; STATUS and holes ignore writes
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shadow_l_r <= 32'd0;
      shadow_h_r <= 32'd0;
      scan_en_r  <= 1'b0;
      irq_en_r   <= 1'b0;
      bright_r   <= 4'd0;
      prescale_r <= DEF_PRESCALE;
    end else if (wb_wr_s) begin
      case (reg_sel_s)
        REG_DIGITS_L: shadow_l_r <= byte_merge(shadow_l_r, i_wb_dat, i_wb_sel);
        REG_DIGITS_H: shadow_h_r <= byte_merge(shadow_h_r, i_wb_dat, i_wb_sel);
        REG_CTRL: begin
          if (i_wb_sel[0]) begin
            scan_en_r <= i_wb_dat[0];
            irq_en_r  <= i_wb_dat[1];
          end
          if (i_wb_sel[1]) begin
            bright_r <= i_wb_dat[11:8];
          end
        end
        REG_PRESCALE: begin
          if (i_wb_sel[0]) begin
            prescale_r[7:0] <= i_wb_dat[7:0];
          end
          if (i_wb_sel[1]) begin
            prescale_r[15:8] <= i_wb_dat[15:8];
          end
        end
        default: ;
      endcase
    end
  end

  // Scan sequencing: IDLE -> BLANK (1 tick) -> ON (16 ticks) -> next digit
  always_comb begin
    state_n_s  = state_r;
    digit_n_s  = digit_r;
    on_cnt_n_s = on_cnt_r;
    frame_s    = 1'b0;
    copy_s     = 1'b0;
    clear_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        clear_s    = 1'b1;
        digit_n_s  = 3'd0;
        on_cnt_n_s = 4'd0;
        if (scan_en_r) begin
          state_n_s = ST_BLANK;
          copy_s    = 1'b1;
        end else begin
          state_n_s = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (!scan_en_r) begin
          state_n_s  = ST_IDLE;
          digit_n_s  = 3'd0;
          on_cnt_n_s = 4'd0;
        end else if (tick_s) begin
          if (on_cnt_r == BLANK_LAST) begin
            state_n_s  = ST_ON;
            on_cnt_n_s = 4'd0;
          end else begin
            on_cnt_n_s = on_cnt_r + 4'd1;
          end
        end else begin
          state_n_s = ST_BLANK;
        end
      end
      ST_ON: begin
        if (!scan_en_r) begin
          state_n_s  = ST_IDLE;
          digit_n_s  = 3'd0;
          on_cnt_n_s = 4'd0;
        end else if (tick_s) begin
          if (on_cnt_r == ON_LAST) begin
            state_n_s  = ST_BLANK;
            on_cnt_n_s = 4'd0;
            digit_n_s  = digit_r + 3'd1;
            if (digit_r == 3'd7) begin
              frame_s = 1'b1;
              copy_s  = 1'b1;
            end else begin
              frame_s = 1'b0;
            end
          end else begin
            on_cnt_n_s = on_cnt_r + 4'd1;
          end
        end else begin
          state_n_s = ST_ON;
        end
      end
      default: begin
        state_n_s  = ST_IDLE;
        digit_n_s  = 3'd0;
        on_cnt_n_s = 4'd0;
      end
    endcase
  end

  // Scanner state, frame counter and frame interrupt pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      digit_r     <= 3'd0;
      on_cnt_r    <= 4'd0;
      frame_cnt_r <= 16'd0;
      irq_r       <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      digit_r     <= digit_n_s;
      on_cnt_r    <= on_cnt_n_s;
      frame_cnt_r <= frame_cnt_r + {15'd0, frame_s};
      irq_r       <= frame_s & irq_en_r;
    end
  end

  // Shadow-to-active copy at scan start and at each frame boundary
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      active_l_r <= 32'd0;
      active_h_r <= 32'd0;
    end else if (copy_s) begin
      active_l_r <= shadow_l_r;
      active_h_r <= shadow_h_r;
    end
  end

  // Lit only in ON, inside the brightness window, with the digit enabled
  always_comb begin
    active_all_s = {active_h_r, active_l_r};
    digit_byte_s = active_all_s[{digit_r, 3'b000} +: 8];
    lit_s        = (state_r == ST_ON) && (on_cnt_r < bright_r) && digit_byte_s[7];
    an_n_s       = 8'hFF;
    seg_n_s      = 7'h7F;
    if (lit_s) begin
      an_n_s  = ~(8'd1 << digit_r);
      seg_n_s = digit_byte_s[6:0];
    end else begin
      an_n_s  = 8'hFF;
      seg_n_s = 7'h7F;
    end
  end

  // Display outputs registered one clock behind the scanner state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      an_r  <= 8'hFF;
      seg_r <= 7'h7F;
    end else begin
      an_r  <= an_n_s;
      seg_r <= seg_n_s;
    end
  end

endmodule

// File: tb/tb_swervolf_sevseg_scan.sv
// Self-checking bench for swervolf_sevseg_scan: register table, scan
// sequences against a frame-arithmetic reference model, and corner cases.
module tb_swervolf_sevseg_scan;

  logic        clk;
  logic        rst;
  logic [4:0]  wb_adr;
  logic [31:0] wb_dat;
  logic [3:0]  wb_sel;
  logic        wb_we;
  logic        wb_cyc;
  logic        wb_stb;
  logic [31:0] wb_rdt;
  logic        wb_ack;
  logic        frame_irq;
  logic [7:0]  an;
  logic [6:0]  seg;

  int checks;
  int failures;
  int cyc_cnt;

  localparam int SLOT  = 17;        // blank tick + 16 on ticks
  localparam int FRAME = 8 * SLOT;  // 136 ticks per frame

  swervolf_sevseg_scan dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wb_adr    (wb_adr),
    .i_wb_dat    (wb_dat),
    .i_wb_sel    (wb_sel),
    .i_wb_we     (wb_we),
    .i_wb_cyc    (wb_cyc),
    .i_wb_stb    (wb_stb),
    .o_wb_rdt    (wb_rdt),
    .o_wb_ack    (wb_ack),
    .o_frame_irq (frame_irq),
    .AN          (an),
    .Digits_Bits (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wb_xfer(input logic wr, input logic [4:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdt);
    logic got;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = wr;
    wb_adr = adr;  wb_dat = dat;  wb_sel = sel;
    got = 1'b0;
    rdt = 32'd0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (wb_ack) begin
        got = 1'b1;
        rdt = wb_rdt;
      end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL wb_timeout: no ack at adr %h", adr);
    end
  endtask

  task automatic do_reset();
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = 5'd0; wb_dat = 32'd0; wb_sel = 4'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Program and enable; returns on the negedge just before scan cycle 0
  task automatic start_scan(input logic [15:0] ps, input logic [31:0] dl,
                            input logic [31:0] dh, input logic [31:0] ctrl);
    logic [31:0] d;
    wb_xfer(1'b1, 5'h0C, {16'd0, ps}, 4'hF, d);
    wb_xfer(1'b1, 5'h00, dl, 4'hF, d);
    wb_xfer(1'b1, 5'h04, dh, 4'hF, d);
    wb_xfer(1'b1, 5'h08, ctrl, 4'hF, d);
  endtask

  // Expected display t clocks after scanning began (t<0: not yet scanning)
  function automatic void model_disp(input int t, input logic [63:0] dig_a, input logic [63:0] dig_b,
                                     input int sw_frame, input int br, input int eff,
                                     output logic [7:0] e_an, output logic [6:0] e_seg);
    int u, slot, d, f;
    logic [63:0] dig;
    logic [7:0]  b;
    logic [7:0]  one;
    e_an  = 8'hFF;
    e_seg = 7'h7F;
    if (t >= 0) begin
      u    = t / eff;
      f    = u / FRAME;
      slot = u % SLOT;
      d    = (u / SLOT) % 8;
      dig  = (f >= sw_frame) ? dig_b : dig_a;
      b    = dig[d*8 +: 8];
      if (slot >= 1 && (slot - 1) < br && b[7]) begin
        one   = 8'h01;
        e_an  = ~(one << d);
        e_seg = b[6:0];
      end
    end
  endfunction

  // Compare AN/Digits_Bits/irq per clock against the model; optional DIGITS_L write mid-run
  task automatic scan_check(input string name, input int ncyc, input logic [63:0] dig_a,
                            input logic [63:0] dig_b, input int sw_frame, input int br,
                            input int eff, input logic irq_en, input int wr_at,
                            input logic [31:0] wr_val);
    int bad_disp, bad_irq, first_p, first_ip;
    logic [7:0] e_an, a_an;
    logic [6:0] e_seg, a_seg;
    logic e_irq, a_irq;
    logic [31:0] d;
    bad_disp = 0; bad_irq = 0; first_p = -1; first_ip = -1;
    e_an = 8'hFF; a_an = 8'hFF; e_seg = 7'h7F; a_seg = 7'h7F; e_irq = 1'b0; a_irq = 1'b0;
    fork
      begin
        for (int p = 0; p < ncyc; p++) begin
          logic [7:0] x_an;
          logic [6:0] x_seg;
          logic       x_irq;
          @(negedge clk);
          model_disp(p - 1, dig_a, dig_b, sw_frame, br, eff, x_an, x_seg);
          if (an !== x_an || seg !== x_seg) begin
            if (bad_disp == 0) begin
              first_p = p; e_an = x_an; e_seg = x_seg; a_an = an; a_seg = seg;
            end
            bad_disp++;
          end
          x_irq = irq_en && (p > 0) && ((p % (FRAME * eff)) == 0);
          if (frame_irq !== x_irq) begin
            if (bad_irq == 0) begin
              first_ip = p; e_irq = x_irq; a_irq = frame_irq;
            end
            bad_irq++;
          end
        end
      end
      begin
        if (wr_at >= 0) begin
          repeat (wr_at) @(negedge clk);
          wb_xfer(1'b1, 5'h00, wr_val, 4'hF, d);
        end
      end
    join
    checks++;
    if (bad_disp != 0) begin
      failures++;
      $display("FAIL %s display: %0d bad cycles, first at %0d AN=%h seg=%h expected AN=%h seg=%h",
               name, bad_disp, first_p, a_an, a_seg, e_an, e_seg);
    end
    checks++;
    if (bad_irq != 0) begin
      failures++;
      $display("FAIL %s irq: %0d bad cycles, first at %0d got %b expected %b",
               name, bad_irq, first_ip, a_irq, e_irq);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [4:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [31:0] rd;
    logic [63:0] dig;
    logic [63:0] dig_new;
    int          br, eff, ps, prev_t, now_t;
    logic        irq_en, found;
    string       nm;

    checks = 0; failures = 0; cyc_cnt = 0;
    rst = 1'b1;

    // Register map: write (optional) then read back
    vecs[0]  = '{1'b0, 5'h00, 32'h0,        4'hF, 32'h00000000};
    vecs[1]  = '{1'b0, 5'h08, 32'h0,        4'hF, 32'h00000000};
    vecs[2]  = '{1'b0, 5'h0C, 32'h0,        4'hF, 32'h0000186A};
    vecs[3]  = '{1'b0, 5'h10, 32'h0,        4'hF, 32'h00000000};
    vecs[4]  = '{1'b1, 5'h00, 32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
    vecs[5]  = '{1'b1, 5'h00, 32'h12345678, 4'h5, 32'hFF34FF78};
    vecs[6]  = '{1'b1, 5'h04, 32'hA5A5A5A5, 4'hC, 32'hA5A50000};
    vecs[7]  = '{1'b1, 5'h08, 32'hFFFFFFFF, 4'h2, 32'h00000F00};
    vecs[8]  = '{1'b1, 5'h08, 32'hFFFFFFFE, 4'h1, 32'h00000F02};
    vecs[9]  = '{1'b1, 5'h0C, 32'hFFFF1234, 4'hF, 32'h00001234};
    vecs[10] = '{1'b1, 5'h0C, 32'h0000AB00, 4'h2, 32'h0000AB34};
    vecs[11] = '{1'b1, 5'h10, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vecs[12] = '{1'b1, 5'h14, 32'hFFFFFFFF, 4'hF, 32'h00000000};
    vecs[13] = '{1'b1, 5'h1C, 32'h12345678, 4'hF, 32'h00000000};
    vecs[14] = '{1'b0, 5'h03, 32'h0,        4'hF, 32'hFF34FF78};

    do_reset();
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].wr) wb_xfer(1'b1, vecs[i].adr, vecs[i].dat, vecs[i].sel, rd);
      wb_xfer(1'b0, vecs[i].adr, 32'd0, 4'hF, rd);
      nm = $sformatf("reg_vec[%0d]", i);
      chk(nm, rd, vecs[i].exp);
    end

    // Held cyc/stb: ack toggles, one wait state per access
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 5'h0C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("ack_toggle", {31'd0, wb_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;

    // Full scan sequence, BRIGHT=15, PRESCALE=0
    do_reset();
    dig = {32'h83828180, 32'h8F8E8D8C};
    start_scan(16'd0, dig[31:0], dig[63:32], 32'h00000F01);
    scan_check("scan_seq", 2 * FRAME + 4, dig, dig, 99, 15, 1, 1'b0, -1, 32'd0);

    // Tear-free update: DIGITS_L written mid-frame shows from the next frame
    do_reset();
    dig_new = {32'h83828180, 32'h00C5C4C3};
    start_scan(16'd0, dig[31:0], dig[63:32], 32'h00000F01);
    scan_check("tear_free", 2 * FRAME + 4, dig, dig_new, 1, 15, 1, 1'b0, 60, 32'h00C5C4C3);

    // BRIGHT=0 keeps the display dark
    do_reset();
    start_scan(16'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    scan_check("bright0", FRAME + 8, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 99, 0, 1, 1'b0, -1, 32'd0);

    // Randomized configurations against the reference model
    for (int r = 0; r < 4; r++) begin
      do_reset();
      dig    = {$urandom, $urandom};
      br     = int'($urandom_range(15, 0));
      ps     = int'($urandom_range(3, 0));
      eff    = (ps == 0) ? 1 : ps;
      irq_en = 1'($urandom_range(1, 0));
      start_scan(16'(ps), dig[31:0], dig[63:32], {20'd0, 4'(br), 6'd0, irq_en, 1'b1});
      nm = $sformatf("rand[%0d] ps=%0d br=%0d", r, ps, br);
      scan_check(nm, 2 * FRAME * eff + 6, dig, dig, 99, br, eff, irq_en, -1, 32'd0);
    end

    // Frame IRQ period and frame counter in STATUS
    do_reset();
    start_scan(16'd0, 32'h8F8E8D8C, 32'h83828180, 32'h00000F03);
    prev_t = 0;
    for (int k = 1; k <= 3; k++) begin
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
        @(negedge clk);
        if (frame_irq) found = 1'b1;
      end
      chk("irq_seen", {31'd0, found}, 32'd1);
      now_t = cyc_cnt;
      if (k > 1) chk("irq_period", now_t - prev_t, FRAME);
      prev_t = now_t;
      wb_xfer(1'b0, 5'h10, 32'd0, 4'hF, rd);
      chk("status_frame", rd, {16'(k), 16'h0020});
    end

    // Disable during ON of digit 3
    do_reset();
    start_scan(16'd0, 32'h8F8E8D8C, 32'h83828180, 32'h00000F01);
    repeat (56) @(negedge clk);
    wb_xfer(1'b1, 5'h08, 32'h00000F00, 4'hF, rd);
    @(negedge clk);
    chk("dis_lag_an", {24'd0, an}, 32'h000000F7);
    chk("dis_lag_seg", {25'd0, seg}, 32'h0000000F);
    @(negedge clk);
    chk("dis_an_off", {24'd0, an}, 32'h000000FF);
    chk("dis_seg_off", {25'd0, seg}, 32'h0000007F);
    wb_xfer(1'b0, 5'h10, 32'd0, 4'hF, rd);
    chk("dis_status", rd, 32'h00000000);
    repeat (20) @(negedge clk);
    chk("dis_stays_dark", {24'd0, an}, 32'h000000FF);

    // Asynchronous reset mid-cycle with a lit digit and an access in flight
    do_reset();
    start_scan(16'd0, 32'h8F8E8D8C, 32'h83828180, 32'h00000F01);
    repeat (20) @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 5'h0C;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_an", {24'd0, an}, 32'h000000FF);
    chk("rst_seg", {25'd0, seg}, 32'h0000007F);
    chk("rst_ack", {31'd0, wb_ack}, 32'd0);
    @(negedge clk);
    chk("rst_ack_held", {31'd0, wb_ack}, 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    wb_xfer(1'b0, 5'h0C, 32'd0, 4'hF, rd);
    chk("rst_prescale", rd, 32'd6250);
    wb_xfer(1'b0, 5'h08, 32'd0, 4'hF, rd);
    chk("rst_ctrl", rd, 32'd0);
    wb_xfer(1'b0, 5'h04, 32'd0, 4'hF, rd);
    chk("rst_digits_h", rd, 32'd0);
    wb_xfer(1'b0, 5'h10, 32'd0, 4'hF, rd);
    chk("rst_status", rd, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/swervolf_sevseg_scan.md
SWERVOLF_SEVSEG_SCAN -- requirements
Module: swervolf_sevseg_scan

Interface
REQ-001 SHALL have parameter DEF_PRESCALE, default 16'd6250, giving the reset value of PRESCALE in clocks per scan tick.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have ports i_wb_adr [4:0], i_wb_dat [31:0], i_wb_sel [3:0], i_wb_we, i_wb_cyc and i_wb_stb as inputs, forming a Wishbone slave.
REQ-005 SHALL have ports o_wb_rdt [31:0] and o_wb_ack [1] as outputs, returning read data and acknowledge.
REQ-006 SHALL have port o_frame_irq, output, 1, a one-cycle pulse at each frame boundary.
REQ-007 SHALL have port AN, output, 8, active-low digit anodes.
REQ-008 SHALL have port Digits_Bits, output, 7, segment bits of the selected digit.

Function
REQ-009 SHALL set o_wb_ack <= i_wb_cyc & i_wb_stb & !o_wb_ack, acknowledging every access after one wait state.
REQ-010 SHALL commit a write when cyc & stb & we & !ack, honouring each byte lane of i_wb_sel.
REQ-011 SHALL decode registers on i_wb_adr[4:2]: 0 DIGITS_L, 1 DIGITS_H, 2 CTRL, 3 PRESCALE[15:0], 4 STATUS (read-only); all other addresses read 0 and ignore writes.
REQ-012 SHALL use this digit byte format: per digit byte, bits 6:0 are segments and bit 7 is digit enable; DIGITS_L holds digits 0-3 and DIGITS_H holds digits 4-7, with the low byte as the lowest digit.
REQ-013 SHALL lay out CTRL as: bit0 SCAN_EN, bit1 IRQ_EN, bits 11:8 BRIGHT.
REQ-014 SHALL lay out STATUS as: bits 2:0 current digit, bits 5:4 FSM state, bits 31:16 frame counter.
REQ-015 SHALL let Wishbone write only the shadow DIGITS registers.
REQ-016 SHALL copy the shadow registers into the active registers at every frame boundary and on SCAN_EN rising, so no frame tears.
REQ-017 SHALL generate the prescaler tick by down-counting from PRESCALE; tick fires when the count reaches 0, then the counter reloads.
REQ-018 SHALL treat PRESCALE=0 as 1, i.e. one tick per clock.
REQ-019 SHALL apply a new PRESCALE value at the next reload.
REQ-020 SHALL implement FSM states IDLE, BLANK and ON.
REQ-021 SHALL hold IDLE while SCAN_EN=0; on SCAN_EN=1 it SHALL go to BLANK with digit=0 and the prescaler reloaded.
REQ-022 SHALL keep BLANK for 1 tick with AN=8'hFF and Digits_Bits=7'h7F, then go to ON.
REQ-023 SHALL keep ON for 16 ticks, with on_cnt running 0-15.
REQ-024 SHALL light the digit during ON only when on_cnt < BRIGHT and the digit enable bit is 1; otherwise outputs stay blanked.
REQ-025 SHALL, at the end of ON, advance the digit with wrap 7->0 and return to BLANK.
REQ-026 SHALL treat the 7->0 wrap as the frame boundary: shadow copied, frame counter +1 (wraps at 16'hFFFF->0), and o_frame_irq=IRQ_EN for that cycle.
REQ-027 SHALL register AN and Digits_Bits, one clock after the FSM state and counters.
REQ-028 SHALL, when SCAN_EN is cleared mid-operation, enter IDLE on the next clock, blank outputs, zero digit and on_cnt, and leave the frame counter unchanged.
REQ-029 SHALL, when a DIGITS write coincides with a frame boundary, copy the pre-write shadow; the new value shows from the following frame.
REQ-030 SHALL make BRIGHT=0 keep the display dark and BRIGHT=15 give a 15/16 on-duty.

Reset
REQ-031 SHALL, on i_rst, clear o_wb_ack, o_wb_rdt, o_frame_irq, CTRL, shadow, active, digit, on_cnt and frame counter, and set the state to IDLE.
REQ-032 SHALL, on i_rst, set AN=8'hFF, Digits_Bits=7'h7F and PRESCALE=DEF_PRESCALE.
REQ-033 SHALL abort any in-flight Wishbone access on reset, with no ack issued.

Structure
REQ-034 SHALL place the FSM state enum, register offsets, ON_TICKS=16 and BLANK_TICKS=1 in package swervolf_sevseg_pkg.
REQ-035 SHALL implement the tick generator as sub-module swervolf_sevseg_prescaler, with inputs clk, rst, clear and reload[15:0] and output tick.

Verification
REQ-036 SHALL verify reset: assert i_rst mid-cycle -> AN=FF, Digits_Bits=7F, o_wb_ack=0 immediately; read PRESCALE=6250 after release.
REQ-037 SHALL verify the scan sequence: PRESCALE=0, DIGITS_L=32'h8F8E8D8C, DIGITS_H=32'h83828180, CTRL=32'h0F01 -> AN walks FE,FD,...,7F, each digit 15 of 17 clocks lit, with Digits_Bits matching its byte[6:0].
REQ-038 SHALL verify tear-free update: write DIGITS_L mid-frame -> active value unchanged until the digit 7->0 wrap, then the new value appears.
REQ-039 SHALL verify the frame IRQ: IRQ_EN=1, PRESCALE=0 -> o_frame_irq pulses once every 136 clocks and STATUS[31:16] increments each pulse.
REQ-040 SHALL verify disable mid-scan: clear SCAN_EN during ON of digit 3 -> next clock IDLE, AN=FF one clock later, and STATUS digit=0.
REQ-041 SHALL verify brightness extremes: BRIGHT=0 -> AN stays FF for a full frame; a disabled-digit byte of 8'h00 keeps that anode high.
